// File: rtl/oam_dma_if.sv
// rtl/oam_dma_if.sv - CPU register bus seen by the OAM DMA engine
interface oam_dma_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_in;
  logic        cpu_we;
  logic [7:0]  cpu_data_out;

  modport master (
    output cpu_addr,
    output cpu_data_in,
    output cpu_we,
    input  cpu_data_out
  );

  modport slave (
    input  cpu_addr,
    input  cpu_data_in,
    input  cpu_we,
    output cpu_data_out
  );
endinterface

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - OAM DMA engine copying LENGTH bytes from a source page to DEST_BASE
module oam_dma #(
  parameter int          LENGTH    = 160,
  parameter logic [15:0] DEST_BASE = 16'hFE00,
  parameter logic [15:0] REG_ADDR  = 16'hFF46
) (
  input  logic        clock,
  input  logic        reset,
  oam_dma_if.slave    cpu,
  output logic [15:0] dma_addr,
  inout  wire  [7:0]  dma_data,
  output logic        dma_re,
  output logic        dma_we,
  output logic        dma_active,
  output logic        dma_done
);

  typedef enum logic [1:0] {IDLE, START, READ, WRITE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(LENGTH - 1);

  state_t     state, state_next;
  logic [7:0] src_page, src_page_next;
  logic [7:0] idx, idx_next;
  logic [7:0] byte_latch, byte_latch_next;
  logic       done_next;
  logic       reg_write;

  assign reg_write = cpu.cpu_we && (cpu.cpu_addr == REG_ADDR);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      src_page   <= 8'h00;
      idx        <= 8'h00;
      byte_latch <= 8'h00;
      dma_done   <= 1'b0;
    end else begin
      state      <= state_next;
      src_page   <= src_page_next;
      idx        <= idx_next;
      byte_latch <= byte_latch_next;
      dma_done   <= done_next;
    end
  end

  always_comb begin
    state_next      = state;
    src_page_next   = src_page;
    idx_next        = idx;
    byte_latch_next = byte_latch;
    done_next       = 1'b0;
    dma_addr        = 16'h0000;
    dma_re          = 1'b0;
    dma_we          = 1'b0;
    dma_active      = 1'b0;

    case (state)
      IDLE: begin
        state_next = IDLE;
      end
      START: begin
        idx_next   = 8'h00;
        state_next = READ;
      end
      READ: begin
        dma_active      = 1'b1;
        dma_re          = 1'b1;
        dma_addr        = {src_page, 8'h00} + {8'h00, idx};
        byte_latch_next = dma_data;
        state_next      = WRITE;
      end
      WRITE: begin
        dma_active = 1'b1;
        dma_we     = 1'b1;
        dma_addr   = DEST_BASE + {8'h00, idx};
        if (idx == LAST_IDX) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end else begin
          idx_next   = idx + 8'h01;
          state_next = READ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // A register write always wins: it restarts the copy and cancels any pending completion.
    if (reg_write) begin
      src_page_next = cpu.cpu_data_in;
      idx_next      = 8'h00;
      done_next     = 1'b0;
      state_next    = START;
    end
  end

  assign dma_data         = dma_we ? byte_latch : 8'bzzzzzzzz;
  assign cpu.cpu_data_out = (cpu.cpu_addr == REG_ADDR) ? src_page : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - directed self-checking bench for oam_dma (default and LENGTH=1 instances)
module tb_oam_dma;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  oam_dma_if bus_a ();
  oam_dma_if bus_b ();

  logic [15:0] addr_a, addr_b;
  wire  [7:0]  data_a, data_b;
  logic        re_a, we_a, act_a, done_a;
  logic        re_b, we_b, act_b, done_b;

  oam_dma dut_a (
    .clock(clock), .reset(reset), .cpu(bus_a),
    .dma_addr(addr_a), .dma_data(data_a), .dma_re(re_a), .dma_we(we_a),
    .dma_active(act_a), .dma_done(done_a)
  );

  oam_dma #(.LENGTH(1)) dut_b (
    .clock(clock), .reset(reset), .cpu(bus_b),
    .dma_addr(addr_b), .dma_data(data_b), .dma_re(re_b), .dma_we(we_b),
    .dma_active(act_b), .dma_done(done_b)
  );

  // Source memory is a fixed pattern per page, so no preload is needed.
  function automatic logic [7:0] src_byte(input logic [15:0] a);
    case (a[15:8])
      8'hC0:   return a[7:0] ^ 8'h5A;
      8'hD0:   return a[7:0] ^ 8'hA5;
      8'hFF:   return ~a[7:0];
      8'h80:   return a[7:0] ^ 8'h3C;
      default: return 8'h00;
    endcase
  endfunction

  assign data_a = re_a ? src_byte(addr_a) : 8'bzzzzzzzz;
  assign data_b = re_b ? src_byte(addr_b) : 8'bzzzzzzzz;

  logic [7:0]  wmem [0:65535];
  int          writes_a = 0;
  logic [15:0] last_waddr_a = 16'h0000;
  int          writes_b = 0;
  logic [15:0] last_waddr_b = 16'h0000;
  logic [7:0]  last_wdata_b = 8'h00;

  always @(posedge clock) begin
    if (we_a) begin
      wmem[addr_a] <= data_a;
      writes_a     <= writes_a + 1;
      last_waddr_a <= addr_a;
    end
    if (we_b) begin
      writes_b     <= writes_b + 1;
      last_waddr_b <= addr_b;
      last_wdata_b <= data_b;
    end
  end

  int edge_cnt = 0;
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  int act_a_cnt = 0, done_a_cnt = 0, done_b_cnt = 0, overlap_cnt = 0;
  always @(negedge clock) begin
    if (act_a) act_a_cnt <= act_a_cnt + 1;
    if (done_a) done_a_cnt <= done_a_cnt + 1;
    if (done_b) done_b_cnt <= done_b_cnt + 1;
    if ((re_a && we_a) || (re_b && we_b)) overlap_cnt <= overlap_cnt + 1;
  end

  int checks = 0;
  int errors = 0;
  int write_edge = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Returns 1 time unit after the rising edge that samples the write.
  task automatic cpu_write(input bit sel_b, input logic [15:0] a, input logic [7:0] d);
    @(negedge clock);
    if (sel_b) begin
      bus_b.cpu_addr = a; bus_b.cpu_data_in = d; bus_b.cpu_we = 1'b1;
    end else begin
      bus_a.cpu_addr = a; bus_a.cpu_data_in = d; bus_a.cpu_we = 1'b1;
    end
    @(posedge clock);
    #1;
    bus_a.cpu_we = 1'b0;
    bus_b.cpu_we = 1'b0;
    write_edge = edge_cnt;
  endtask

  // Checks the number of rising edges from the register write to the first visible dma_done.
  task automatic wait_done(input bit sel_b, input int exp_edges, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 1000 && !seen; i++) begin
      @(negedge clock);
      if (sel_b ? done_b : done_a) seen = 1'b1;
    end
    check(tag, seen ? (edge_cnt - write_edge) : -1, exp_edges);
  endtask

  initial begin
    int a0, d0, w0, bad;

    reset = 1'b1;
    bus_a.cpu_addr = 16'hFF46; bus_a.cpu_data_in = 8'h00; bus_a.cpu_we = 1'b0;
    bus_b.cpu_addr = 16'hFF46; bus_b.cpu_data_in = 8'h00; bus_b.cpu_we = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    check("reset_bus_flags", {act_a, re_a, we_a}, 3'b000);
    check("reset_addr", addr_a, 16'h0000);
    check("reset_done", done_a, 1'b0);
    check("reset_readback", bus_a.cpu_data_out, 8'h00);

    // Default copy from page C0
    a0 = act_a_cnt; d0 = done_a_cnt; w0 = writes_a;
    cpu_write(0, 16'hFF46, 8'hC0);
    @(negedge clock);
    check("start_flags", {act_a, re_a, we_a}, 3'b000);
    check("start_addr", addr_a, 16'h0000);
    @(negedge clock);
    check("rd0_addr", addr_a, 16'hC000);
    check("rd0_flags", {act_a, re_a, we_a}, 3'b110);
    @(negedge clock);
    check("wr0_addr", addr_a, 16'hFE00);
    check("wr0_flags", {act_a, re_a, we_a}, 3'b101);
    check("wr0_data", data_a, 8'h5A);
    wait_done(0, 321, "done_edge_a");
    @(negedge clock);
    check("done_pulse_width", done_a, 1'b0);
    check("idle_after_done", act_a, 1'b0);
    repeat (2) @(negedge clock);
    check("active_cycles_a", act_a_cnt - a0, 320);
    check("done_count_a", done_a_cnt - d0, 1);
    check("write_count_a", writes_a - w0, 160);
    check("last_write_addr_a", last_waddr_a, 16'hFE9F);
    check("last_byte_a", wmem[16'hFE9F], 8'hC5);
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (wmem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'h5A)) bad++;
    check("copy_c0", bad, 0);
    check("readback_c0", bus_a.cpu_data_out, 8'hC0);

    // Page FF and register readback decoding
    cpu_write(0, 16'hFF46, 8'hFF);
    @(negedge clock);
    @(negedge clock);
    check("rd0_addr_ff", addr_a, 16'hFF00);
    check("readback_ff46", bus_a.cpu_data_out, 8'hFF);
    bus_a.cpu_addr = 16'hFF45;
    #1;
    check("readback_ff45", bus_a.cpu_data_out, 8'h00);
    bus_a.cpu_addr = 16'hFF46;
    wait_done(0, 321, "done_edge_ff");
    check("first_byte_ff", wmem[16'hFE00], 8'hFF);
    check("last_byte_ff", wmem[16'hFE9F], 8'h60);
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (wmem[16'hFE00 + 16'(i)] !== ~8'(i)) bad++;
    check("copy_ff", bad, 0);

    // Write to a neighbouring address is ignored
    cpu_write(0, 16'hFF45, 8'h12);
    repeat (2) @(negedge clock);
    check("other_addr_no_start", act_a, 1'b0);
    bus_a.cpu_addr = 16'hFF46;
    #1;
    check("other_addr_keeps_page", bus_a.cpu_data_out, 8'hFF);

    // Restart mid-transfer from page D0
    d0 = done_a_cnt;
    cpu_write(0, 16'hFF46, 8'hC0);
    repeat (48) @(negedge clock);
    cpu_write(0, 16'hFF46, 8'hD0);
    wait_done(0, 321, "done_edge_restart");
    repeat (3) @(negedge clock);
    check("done_count_restart", done_a_cnt - d0, 1);
    check("first_byte_d0", wmem[16'hFE00], 8'hA5);
    check("last_byte_d0", wmem[16'hFE9F], 8'h3A);
    bad = 0;
    for (int i = 0; i < 160; i++)
      if (wmem[16'hFE00 + 16'(i)] !== (8'(i) ^ 8'hA5)) bad++;
    check("copy_d0", bad, 0);

    // Reset in the middle of a transfer
    d0 = done_a_cnt;
    cpu_write(0, 16'hFF46, 8'hC0);
    repeat (100) @(negedge clock);
    check("pre_reset_active", act_a, 1'b1);
    reset = 1'b1;
    #1;
    check("reset_mid_flags", {act_a, re_a, we_a}, 3'b000);
    check("reset_mid_addr", addr_a, 16'h0000);
    check("reset_mid_done", done_a, 1'b0);
    check("reset_mid_readback", bus_a.cpu_data_out, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("post_reset_idle", act_a, 1'b0);
    repeat (400) @(negedge clock);
    check("reset_no_done", done_a_cnt - d0, 0);
    check("reset_stays_idle", act_a, 1'b0);

    // LENGTH=1 instance
    w0 = writes_b;
    cpu_write(1, 16'hFF46, 8'h80);
    @(negedge clock);
    @(negedge clock);
    check("b_rd_addr", addr_b, 16'h8000);
    check("b_rd_flags", {act_b, re_b, we_b}, 3'b110);
    @(negedge clock);
    check("b_wr_addr", addr_b, 16'hFE00);
    check("b_wr_flags", {act_b, re_b, we_b}, 3'b101);
    wait_done(1, 3, "b_done_edge");
    repeat (2) @(negedge clock);
    check("b_write_count", writes_b - w0, 1);
    check("b_write_addr", last_waddr_b, 16'hFE00);
    check("b_write_data", last_wdata_b, 8'h3C);
    check("b_done_count", done_b_cnt, 1);

    check("re_we_overlap", overlap_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
